spi_dual_rx: RTL and testbench
==============================

SPI_DUAL_RX -- requirements
Module: spi_dual_rx

Interface
REQ-001 Parameter: TIMEOUT_CYC, 64, PCLK cycles allowed between SCLK edges inside a byte before the partial byte is aborted.
REQ-002 Parameter: CPOL, 0, SCLK idle level; bits are sampled on the first edge leaving the idle level (rising when CPOL=0).
REQ-003 Port: PCLK  in  1  system clock, single clock domain.
REQ-004 Port: PRESETN  in  1  reset, asynchronous assertion, active-low.
REQ-005 Port: SCLK  in  1  serial clock from the dual-lane SPI transmitter, asynchronous to PCLK.
REQ-006 Port: SDI_0 / SDI_1  in  1 each  serial data lanes 0 and 1, MSB first.
REQ-007 Port: EN  in  1  receive enable.
REQ-008 Port: RX_READY  in  1  consumer accepts the held byte pair.
REQ-009 Port: OVR_CLR  in  1  one-cycle clear of OVERRUN.
REQ-010 Port: RX_DATA_0 / RX_DATA_1  out  8 each  received bytes for lanes 0 and 1.
REQ-011 Port: RX_VALID  out  1  held byte pair is valid.
REQ-012 Port: RX_BUSY  out  1  a byte is partially received (FSM in RECV).
REQ-013 Port: OVERRUN  out  1  sticky flag: a completed byte pair was dropped.
REQ-014 Port: ABORT  out  1  one-cycle pulse when a partial byte is discarded.
REQ-015 Port: ABORT_CNT  out  8  saturating count of aborts.

Function
REQ-016 SCLK, SDI_0 and SDI_1 SHALL each pass through two PCLK flops; a third SCLK flop SHALL provide sampling-edge detection.
REQ-017 On each detected sampling edge, the synchronized SDI_0 and SDI_1 SHALL shift into separate 8-bit shift registers, MSB first, and the 3-bit bit counter SHALL increment.
REQ-018 FSM states: IDLE (bit count 0) and RECV (1..7 bits received); IDLE->RECV on the first edge; RECV->IDLE on the 8th edge, on timeout, or when EN is low.
REQ-019 On the 8th edge, the full byte pair SHALL complete on that same PCLK edge; the worst-case latency from the SCLK pin edge to RX_VALID high SHALL be 3 PCLK cycles.
REQ-020 Completed pair when RX_VALID is low, or when RX_VALID and RX_READY are both high -> load RX_DATA_0/1 and set RX_VALID (back-to-back accept and reload keeps RX_VALID high).
REQ-021 Completed pair when RX_VALID is high and RX_READY is low -> drop the new pair, keep the old pair, set OVERRUN.
REQ-022 RX_VALID high and RX_READY high with no new completion -> clear RX_VALID on the next edge; RX_DATA holds its last value.
REQ-023 OVERRUN SHALL clear on OVR_CLR; if set and clear occur in the same cycle, set SHALL win.
REQ-024 In RECV, the timeout counter SHALL reload on each sampling edge and increment otherwise; on reaching TIMEOUT_CYC-1 -> go to IDLE, clear the bit counter, pulse ABORT, and increment ABORT_CNT (saturating at 255).
REQ-025 EN low SHALL force IDLE and clear the bit counter without ABORT; RX_VALID and RX_DATA SHALL be unaffected and RX_READY SHALL still be honoured.
REQ-026 A sampling edge coinciding with a timeout SHALL take precedence; no abort occurs.
REQ-027 Supported SCLK frequency SHALL be at most PCLK/8.

Reset
REQ-028 PRESETN low SHALL asynchronously set: all synchronizer flops to CPOL/0, FSM=IDLE, counters=0, shift registers=0, RX_DATA_0/1=8'h00, RX_VALID=0, RX_BUSY=0, OVERRUN=0, ABORT=0, ABORT_CNT=0.
REQ-029 Reset asserted mid-byte SHALL discard the partial byte with no ABORT pulse; release SHALL be synchronous to PCLK.

Structure
REQ-030 Shared package spi_pkg SHALL hold BYTE_W=8, the FSM state encoding (IDLE, RECV), and the TIMEOUT_CYC default.
REQ-031 Sub-module spi_sync_edge (2-flop synchronizer plus edge detect, CPOL-aware) SHALL be instantiated for SCLK; the data lanes SHALL use its synchronizer-only path so that all three signals share equal delay.

Verification
REQ-032 SCLK=PCLK/8, lanes 0x32/0x45, RX_READY=1 -> RX_VALID pulses once, RX_DATA_0=0x32, RX_DATA_1=0x45, OVERRUN=0.
REQ-033 Bursts 0xAB/0xCD then 0xFF/0x97 with RX_READY=0 -> data stays 0xAB/0xCD, OVERRUN=1; OVR_CLR pulse -> OVERRUN=0.
REQ-034 Send 5 bits, then idle 64 PCLK -> one ABORT pulse, ABORT_CNT=1, RX_BUSY=0; next full byte 0x64/0x88 is received correctly.
REQ-035 RX_READY high in the same cycle as completion of 0x36/0x78 while 0x38/0x96 is held -> RX_VALID stays 1 and data becomes 0x36/0x78.
REQ-036 PRESETN pulsed after 4 bits of 0xA8/0xC4 -> all outputs at reset values, no ABORT; the following byte 0xA8/0xC4 is received intact.
REQ-037 EN low mid-byte -> IDLE, no ABORT, held RX_DATA unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and FSM encoding for the dual-lane SPI receiver.
package spi_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for a small bus; bit 0 additionally gets a third flop
// for sampling-edge detection, so SCLK and the data lanes see equal delay.
module spi_sync_edge #(
  parameter int unsigned   W       = 3,
  parameter logic [W-1:0]  RST_VAL = '0,
  parameter bit            CPOL    = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:1] o_q,
  output logic         o_edge_c
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic         r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL[0];
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2[0];
    end
  end

  // Sampling edge is the first transition leaving the idle level.
  assign o_edge_c = CPOL ? (r_s3 & ~r_s2[0]) : (r_s2[0] & ~r_s3);
  assign o_q      = r_s2[W-1:1];

endmodule

// File: rtl/spi_dual_rx.sv
// Dual-lane SPI receiver: captures one byte per lane per 8 SCLK sampling edges,
// with ready/valid hand-off, sticky overrun and an intra-byte timeout.
module spi_dual_rx
  import spi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter bit          CPOL        = 1'b0
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              SCLK,
  input  logic              SDI_0,
  input  logic              SDI_1,
  input  logic              EN,
  input  logic              RX_READY,
  input  logic              OVR_CLR,
  output logic [BYTE_W-1:0] RX_DATA_0,
  output logic [BYTE_W-1:0] RX_DATA_1,
  output logic              RX_VALID,
  output logic              RX_BUSY,
  output logic              OVERRUN,
  output logic              ABORT,
  output logic [7:0]        ABORT_CNT
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned BC_W = $clog2(BYTE_W);

  logic [1:0]        w_sdi;
  logic              w_edge;

  logic [0:0]        r_state,     w_state_n;
  logic [BC_W-1:0]   r_bit_cnt,   w_bit_cnt_n;
  logic [TO_W-1:0]   r_to_cnt,    w_to_cnt_n;
  logic [BYTE_W-1:0] r_sh0,       w_sh0_n;
  logic [BYTE_W-1:0] r_sh1,       w_sh1_n;
  logic [BYTE_W-1:0] r_data0,     w_data0_n;
  logic [BYTE_W-1:0] r_data1,     w_data1_n;
  logic              r_valid,     w_valid_n;
  logic              r_ovr,       w_ovr_n;
  logic              r_abort,     w_abort;
  logic [7:0]        r_abort_cnt, w_abort_cnt_n;
  logic              w_done;
  logic              w_ovr_set;

  spi_sync_edge #(
    .W       (3),
    .RST_VAL ({2'b00, CPOL}),
    .CPOL    (CPOL)
  ) u_sync (
    .clk      (PCLK),
    .rst_n    (PRESETN),
    .i_d      ({SDI_1, SDI_0, SCLK}),
    .o_q      (w_sdi),
    .o_edge_c (w_edge)
  );

  // Next-state: bit framing, timeout and hand-off to the held byte pair.
  always_comb begin
    w_state_n     = r_state;
    w_bit_cnt_n   = r_bit_cnt;
    w_to_cnt_n    = r_to_cnt;
    w_sh0_n       = r_sh0;
    w_sh1_n       = r_sh1;
    w_data0_n     = r_data0;
    w_data1_n     = r_data1;
    w_valid_n     = r_valid;
    w_abort_cnt_n = r_abort_cnt;
    w_done        = 1'b0;
    w_abort       = 1'b0;
    w_ovr_set     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_bit_cnt_n = '0;
        w_to_cnt_n  = '0;
        if (EN && w_edge) begin
          w_sh0_n     = {r_sh0[BYTE_W-2:0], w_sdi[0]};
          w_sh1_n     = {r_sh1[BYTE_W-2:0], w_sdi[1]};
          w_bit_cnt_n = BC_W'(1);
          w_state_n   = ST_RECV;
        end
      end
      default: begin
        if (!EN) begin
          w_state_n   = ST_IDLE;
          w_bit_cnt_n = '0;
          w_to_cnt_n  = '0;
        end else if (w_edge) begin
          // An edge beats a coincident timeout.
          w_sh0_n    = {r_sh0[BYTE_W-2:0], w_sdi[0]};
          w_sh1_n    = {r_sh1[BYTE_W-2:0], w_sdi[1]};
          w_to_cnt_n = '0;
          if (r_bit_cnt == BC_W'(BYTE_W - 1)) begin
            w_done      = 1'b1;
            w_state_n   = ST_IDLE;
            w_bit_cnt_n = '0;
          end else begin
            w_bit_cnt_n = r_bit_cnt + BC_W'(1);
          end
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_abort     = 1'b1;
          w_state_n   = ST_IDLE;
          w_bit_cnt_n = '0;
          w_to_cnt_n  = '0;
        end else begin
          w_to_cnt_n = r_to_cnt + TO_W'(1);
        end
      end
    endcase

    if (w_done) begin
      if (!r_valid || RX_READY) begin
        w_data0_n = w_sh0_n;
        w_data1_n = w_sh1_n;
        w_valid_n = 1'b1;
      end else begin
        w_ovr_set = 1'b1;
      end
    end else if (r_valid && RX_READY) begin
      w_valid_n = 1'b0;
    end

    w_ovr_n = w_ovr_set | (r_ovr & ~OVR_CLR);

    if (w_abort && (r_abort_cnt != 8'hFF)) begin
      w_abort_cnt_n = r_abort_cnt + 8'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_to_cnt    <= '0;
      r_sh0       <= '0;
      r_sh1       <= '0;
      r_data0     <= '0;
      r_data1     <= '0;
      r_valid     <= 1'b0;
      r_ovr       <= 1'b0;
      r_abort     <= 1'b0;
      r_abort_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_bit_cnt   <= w_bit_cnt_n;
      r_to_cnt    <= w_to_cnt_n;
      r_sh0       <= w_sh0_n;
      r_sh1       <= w_sh1_n;
      r_data0     <= w_data0_n;
      r_data1     <= w_data1_n;
      r_valid     <= w_valid_n;
      r_ovr       <= w_ovr_n;
      r_abort     <= w_abort;
      r_abort_cnt <= w_abort_cnt_n;
    end
  end

  assign RX_DATA_0 = r_data0;
  assign RX_DATA_1 = r_data1;
  assign RX_VALID  = r_valid;
  assign RX_BUSY   = (r_state == ST_RECV);
  assign OVERRUN   = r_ovr;
  assign ABORT     = r_abort;
  assign ABORT_CNT = r_abort_cnt;

endmodule

// File: tb/tb_spi_dual_rx.sv
// Directed bench for spi_dual_rx: SCLK at PCLK/8, hand-computed expected values.
module tb_spi_dual_rx;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic       SCLK;
  logic       SDI_0;
  logic       SDI_1;
  logic       EN;
  logic       RX_READY;
  logic       OVR_CLR;
  logic [7:0] RX_DATA_0;
  logic [7:0] RX_DATA_1;
  logic       RX_VALID;
  logic       RX_BUSY;
  logic       OVERRUN;
  logic       ABORT;
  logic [7:0] ABORT_CNT;

  int total = 0;
  int bad   = 0;
  int valid_cyc = 0;
  int abort_cyc = 0;
  int v0;
  int a0;

  spi_dual_rx #(.TIMEOUT_CYC(64), .CPOL(1'b0)) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .SCLK      (SCLK),
    .SDI_0     (SDI_0),
    .SDI_1     (SDI_1),
    .EN        (EN),
    .RX_READY  (RX_READY),
    .OVR_CLR   (OVR_CLR),
    .RX_DATA_0 (RX_DATA_0),
    .RX_DATA_1 (RX_DATA_1),
    .RX_VALID  (RX_VALID),
    .RX_BUSY   (RX_BUSY),
    .OVERRUN   (OVERRUN),
    .ABORT     (ABORT),
    .ABORT_CNT (ABORT_CNT)
  );

  always #5 PCLK = ~PCLK;

  // Count cycles with RX_VALID / ABORT high, sampled away from the active edge.
  always @(negedge PCLK) begin
    if (RX_VALID === 1'b1) valid_cyc++;
    if (ABORT === 1'b1) abort_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n bits MSB first; starts on a PCLK negedge, 80 ns per SCLK period.
  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input int n);
    for (int i = 0; i < n; i++) begin
      SDI_0 = b0[7-i];
      SDI_1 = b1[7-i];
      #40 SCLK = 1'b1;
      #40 SCLK = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  initial begin
    PRESETN = 1'b0; SCLK = 1'b0; SDI_0 = 1'b0; SDI_1 = 1'b0;
    EN = 1'b1; RX_READY = 1'b0; OVR_CLR = 1'b0;
    cycles(3);
    chk("rst_valid", 32'(RX_VALID), 32'd0);
    chk("rst_data0", 32'(RX_DATA_0), 32'h00);
    chk("rst_data1", 32'(RX_DATA_1), 32'h00);
    chk("rst_busy",  32'(RX_BUSY), 32'd0);
    chk("rst_ovr",   32'(OVERRUN), 32'd0);
    chk("rst_abort", 32'(ABORT), 32'd0);
    chk("rst_acnt",  32'(ABORT_CNT), 32'd0);
    PRESETN = 1'b1;
    cycles(3);

    // Single byte pair with consumer always ready.
    RX_READY = 1'b1;
    v0 = valid_cyc;
    send(8'h32, 8'h45, 8);
    cycles(5);
    chk("basic_vpulse", 32'(valid_cyc - v0), 32'd1);
    chk("basic_d0", 32'(RX_DATA_0), 32'h32);
    chk("basic_d1", 32'(RX_DATA_1), 32'h45);
    chk("basic_ovr", 32'(OVERRUN), 32'd0);
    chk("basic_vlow", 32'(RX_VALID), 32'd0);

    // Overrun: second pair dropped while first is held.
    RX_READY = 1'b0;
    send(8'hAB, 8'hCD, 8);
    cycles(3);
    chk("ovr_v1", 32'(RX_VALID), 32'd1);
    chk("ovr_d0a", 32'(RX_DATA_0), 32'hAB);
    send(8'hFF, 8'h97, 8);
    cycles(3);
    chk("ovr_d0", 32'(RX_DATA_0), 32'hAB);
    chk("ovr_d1", 32'(RX_DATA_1), 32'hCD);
    chk("ovr_set", 32'(OVERRUN), 32'd1);
    OVR_CLR = 1'b1;
    cycles(1);
    OVR_CLR = 1'b0;
    cycles(1);
    chk("ovr_clr", 32'(OVERRUN), 32'd0);
    chk("ovr_vkeep", 32'(RX_VALID), 32'd1);

    // Accept and reload in the same cycle keeps RX_VALID high.
    RX_READY = 1'b1;
    cycles(2);
    RX_READY = 1'b0;
    send(8'h38, 8'h96, 8);
    cycles(3);
    chk("b2b_held0", 32'(RX_DATA_0), 32'h38);
    chk("b2b_held1", 32'(RX_DATA_1), 32'h96);
    send(8'h36, 8'h78, 7);
    SDI_0 = 1'b0; SDI_1 = 1'b0;
    #40 SCLK = 1'b1;
    #20 RX_READY = 1'b1;
    #10 RX_READY = 1'b0;
    #10 SCLK = 1'b0;
    cycles(3);
    chk("b2b_valid", 32'(RX_VALID), 32'd1);
    chk("b2b_d0", 32'(RX_DATA_0), 32'h36);
    chk("b2b_d1", 32'(RX_DATA_1), 32'h78);
    chk("b2b_ovr", 32'(OVERRUN), 32'd0);

    // Timeout after 5 bits, then a clean byte.
    RX_READY = 1'b1;
    cycles(2);
    a0 = abort_cyc;
    send(8'hF0, 8'h0F, 5);
    chk("to_busy", 32'(RX_BUSY), 32'd1);
    cycles(80);
    chk("to_pulse", 32'(abort_cyc - a0), 32'd1);
    chk("to_acnt", 32'(ABORT_CNT), 32'd1);
    chk("to_busy0", 32'(RX_BUSY), 32'd0);
    send(8'h64, 8'h88, 8);
    cycles(5);
    chk("to_d0", 32'(RX_DATA_0), 32'h64);
    chk("to_d1", 32'(RX_DATA_1), 32'h88);

    // Reset mid-byte discards the partial byte silently.
    send(8'hA8, 8'hC4, 4);
    chk("rm_busy", 32'(RX_BUSY), 32'd1);
    a0 = abort_cyc;
    PRESETN = 1'b0;
    #1;
    chk("rm_d0", 32'(RX_DATA_0), 32'h00);
    chk("rm_d1", 32'(RX_DATA_1), 32'h00);
    chk("rm_acnt", 32'(ABORT_CNT), 32'd0);
    chk("rm_busy0", 32'(RX_BUSY), 32'd0);
    chk("rm_valid", 32'(RX_VALID), 32'd0);
    cycles(2);
    PRESETN = 1'b1;
    cycles(2);
    chk("rm_noabort", 32'(abort_cyc - a0), 32'd0);
    RX_READY = 1'b0;
    send(8'hA8, 8'hC4, 8);
    cycles(3);
    chk("rm_v", 32'(RX_VALID), 32'd1);
    chk("rm_rd0", 32'(RX_DATA_0), 32'hA8);
    chk("rm_rd1", 32'(RX_DATA_1), 32'hC4);

    // EN low mid-byte: back to IDLE, no abort, held pair untouched.
    a0 = abort_cyc;
    send(8'h11, 8'h22, 3);
    chk("en_busy", 32'(RX_BUSY), 32'd1);
    EN = 1'b0;
    cycles(3);
    chk("en_busy0", 32'(RX_BUSY), 32'd0);
    EN = 1'b1;
    chk("en_d0", 32'(RX_DATA_0), 32'hA8);
    chk("en_d1", 32'(RX_DATA_1), 32'hC4);
    chk("en_valid", 32'(RX_VALID), 32'd1);
    chk("en_acnt", 32'(ABORT_CNT), 32'd0);
    RX_READY = 1'b1;
    cycles(2);
    send(8'h5A, 8'h3C, 8);
    cycles(5);
    chk("en_nd0", 32'(RX_DATA_0), 32'h5A);
    chk("en_nd1", 32'(RX_DATA_1), 32'h3C);
    cycles(100);
    chk("en_noabort", 32'(abort_cyc - a0), 32'd0);
    chk("en_ovr", 32'(OVERRUN), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
